// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALUop values matching the 1-bit
// slice array, R-type funct codes, and the issue-stage FSM state encoding.
package alu_pkg;

    localparam logic [5:0] OPC_RTYPE   = 6'h00;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_NAND    = 4'b0100;
    localparam logic [3:0] ALU_NOR     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLL     = 4'b1000;
    localparam logic [3:0] ALU_SRL     = 4'b1001;
    localparam logic [3:0] ALU_ADDU    = 4'b1010;
    localparam logic [3:0] ALU_SUBU    = 4'b1110;
    localparam logic [3:0] ALU_SLTU    = 4'b1111;

    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_NAND  = 6'h2C;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type decoder: opcode/funct -> ALUop, shift flag, illegal flag.
import alu_pkg::*;

module alu_funct_decode (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       is_shift,
    output logic       illegal
);

    // Table lookup; anything unrecognised becomes an illegal AND-slot op.
    always_comb begin
        alu_op   = ALU_AND;
        is_shift = 1'b0;
        illegal  = 1'b0;
        if (opcode != OPC_RTYPE) begin
            illegal = 1'b1;
        end else begin
            case (funct)
                FUNCT_AND:  alu_op = ALU_AND;
                FUNCT_OR:   alu_op = ALU_OR;
                FUNCT_ADD:  alu_op = ALU_ADD;
                FUNCT_NAND: alu_op = ALU_NAND;
                FUNCT_NOR:  alu_op = ALU_NOR;
                FUNCT_SUB:  alu_op = ALU_SUB;
                FUNCT_SLT:  alu_op = ALU_SLT;
                FUNCT_SLL:  begin alu_op = ALU_SLL; is_shift = 1'b1; end
                FUNCT_SRL:  begin alu_op = ALU_SRL; is_shift = 1'b1; end
                FUNCT_ADDU: alu_op = ALU_ADDU;
                FUNCT_SUBU: alu_op = ALU_SUBU;
                FUNCT_SLTU: alu_op = ALU_SLTU;
                default:    illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU slice array: decodes funct, buffers operands in
// a single-entry valid/ready buffer, and runs logical shifts one bit per cycle
// because the slices cannot shift.
import alu_pkg::*;

module alu_issue_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               shift_sel,
    output logic [WIDTH-1:0]   shift_res,
    output logic               illegal
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic               shift_sel_q, shift_sel_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   shift_res_q, shift_res_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [3:0] dec_op;
    logic       dec_shift;
    logic       dec_illegal;
    logic       accept;

    alu_funct_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op   (dec_op),
        .is_shift (dec_shift),
        .illegal  (dec_illegal)
    );

    // State and datapath registers; reset discards any partial shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_op_q    <= ALU_AND;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            shift_sel_q <= 1'b0;
            illegal_q   <= 1'b0;
            shift_res_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            shift_sel_q <= shift_sel_d;
            illegal_q   <= illegal_d;
            shift_res_q <= shift_res_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state: shift iteration, buffer drain, new-op load, then flush override.
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        shift_sel_d = shift_sel_q;
        illegal_d   = illegal_q;
        shift_res_d = shift_res_q;
        cnt_d       = cnt_q;

        case (state_q)
            SHIFT: begin
                // The count is checked before decrementing so the buffer
                // becomes visible one edge after the last shift step.
                if (cnt_q == '0) begin
                    state_d = FULL;
                end else begin
                    shift_res_d = (alu_op_q == ALU_SRL) ? (shift_res_q >> 1)
                                                        : (shift_res_q << 1);
                    cnt_d       = cnt_q - CNT_ONE;
                end
            end
            FULL: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // A new op can only be accepted from IDLE or a draining FULL buffer,
        // so it takes precedence over the FULL->IDLE transition above.
        if (accept) begin
            alu_op_d    = dec_op;
            alu_a_d     = rs_val;
            alu_b_d     = rt_val;
            illegal_d   = dec_illegal;
            shift_sel_d = dec_shift;
            if (dec_shift) shift_res_d = rt_val;
            if (dec_shift && (shamt != '0)) begin
                state_d = SHIFT;
                cnt_d   = shamt;
            end else begin
                state_d = FULL;
            end
        end

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Handshake and output drive derived from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == FULL) && out_ready);
        accept    = in_valid && in_ready;
        out_valid = (state_q == FULL);
        alu_op    = alu_op_q;
        alu_a     = alu_a_q;
        alu_b     = alu_b_q;
        shift_sel = shift_sel_q;
        shift_res = shift_res_q;
        illegal   = illegal_q;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed reset-mid-shift check, then random
// traffic compared against a transaction-level model of the buffer.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        shift_sel;
    logic [31:0] shift_res;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .shamt     (shamt),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .shift_sel (shift_sel),
        .shift_res (shift_res),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference decode table: returns {illegal, is_shift, alu_op}.
    function automatic logic [5:0] ref_dec(input logic [5:0] opc, input logic [5:0] fn);
        if (opc != 6'h00) return 6'b10_0000;
        case (fn)
            6'h24: return 6'b00_0000;
            6'h25: return 6'b00_0001;
            6'h20: return 6'b00_0010;
            6'h2C: return 6'b00_0100;
            6'h27: return 6'b00_0101;
            6'h22: return 6'b00_0110;
            6'h2A: return 6'b00_0111;
            6'h00: return 6'b01_1000;
            6'h02: return 6'b01_1001;
            6'h21: return 6'b00_1010;
            6'h23: return 6'b00_1110;
            6'h2B: return 6'b00_1111;
            default: return 6'b10_0000;
        endcase
    endfunction

    logic [5:0] functs [14] = '{6'h24, 6'h25, 6'h20, 6'h2C, 6'h27, 6'h22, 6'h2A,
                                6'h00, 6'h02, 6'h21, 6'h23, 6'h2B, 6'h3F, 6'h01};

    // Transaction-level model: one buffered item that becomes visible at a
    // given edge count; shifts are computed with plain shift operators.
    bit          has_item;
    int          ready_cyc;
    int          cyc;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    logic        m_sel, m_ill;
    bit          visible, exp_in_ready;
    logic [5:0]  d;
    int          n_txn;

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_op", alu_op, 0);
        check("rst_shift_sel", shift_sel, 0);
        check("rst_shift_res", shift_res, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;

        // Reset in the middle of an SLL by 20.
        @(negedge clk);
        in_valid = 1'b1; opcode = 6'h00; funct = 6'h00; shamt = 5'd20;
        rs_val = 32'h1234_5678; rt_val = 32'h0000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("shift_in_ready", in_ready, 0);
            check("shift_out_valid", out_valid, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_shift_res", shift_res, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_b", alu_b, 0);
        check("midrst_shift_sel", shift_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 1);
        check("postrst_out_valid", out_valid, 0);

        // Random traffic against the model.
        has_item = 0; ready_cyc = 0; cyc = 0; n_txn = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 24) == 0);
            opcode    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            funct     = functs[$urandom_range(0, 13)];
            shamt     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            rs_val    = $urandom;
            rt_val    = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom;
            #1;
            visible      = has_item && (cyc >= ready_cyc);
            exp_in_ready = !has_item || (visible && out_ready);
            check("in_ready", in_ready, exp_in_ready);
            check("out_valid", out_valid, visible);
            if (visible) begin
                check("alu_op", alu_op, m_op);
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                check("shift_sel", shift_sel, m_sel);
                check("illegal", illegal, m_ill);
                if (m_sel) check("shift_res", shift_res, m_res);
            end
            @(posedge clk);
            cyc++;
            if (flush) begin
                has_item = 0;
            end else begin
                if (visible && out_ready) begin
                    n_txn++;
                    $display("txn %0d op=%b a=%h b=%h sel=%0d res=%h ill=%0d",
                             n_txn, m_op, m_a, m_b, m_sel, m_sel ? m_res : 32'h0, m_ill);
                    has_item = 0;
                end
                if (in_valid && exp_in_ready) begin
                    d     = ref_dec(opcode, funct);
                    m_op  = d[3:0];
                    m_sel = d[4];
                    m_ill = d[5];
                    m_a   = rs_val;
                    m_b   = rt_val;
                    m_res = (m_op == 4'b1001) ? (rt_val >> shamt) : (rt_val << shamt);
                    has_item  = 1;
                    ready_cyc = (m_sel && shamt != 0) ? cyc + int'(shamt) + 1 : cyc;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
